wbu_commit: RTL and testbench

- Write-back/commit stage directly downstream of the load-store stage.
- Accepts one retired instruction per handshake and writes the GPR file (32x32, x0 hardwired to zero) and the 4-entry machine CSR file.
- Performs the ecall trap update, then hands the next PC to the fetch stage over a valid/ready handshake.
- Provides GPR/CSR read ports and hazard information to decode.

---
 rtl/wbu_commit_if.sv | 37 +++
 rtl/wbu_commit.sv | 165 ++++++++++++++++
 tb/tb_wbu_commit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_commit_if.sv
// Handshake bundle around the write-back/commit stage. It carries the
// upstream retire transaction and the next-PC hand-off to fetch.
// master: the side that feeds retired instructions and consumes the next PC.
// slave : the commit stage itself.
interface wbu_commit_if #(
  parameter int XLEN = 32
);
  // Handshakes: a beat moves on a rising clk edge where valid && ready are
  // both high. A valid source holds its payload stable until that edge.
  logic            wbu_receive_valid;
  logic            wbu_send_ready;
  logic [XLEN-1:0] wd_i;
  logic [XLEN-1:0] csr_wd_i;
  logic [4:0]      rd_i;
  logic [1:0]      csr_rd_i;
  logic            reg_en_i;
  logic            csreg_en_i;
  logic            ecall_i;
  logic            ebreak_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] pc_next_i;
  logic            wbu_send_valid;
  logic            ifu_ready;
  logic [XLEN-1:0] pc_next_o;

  modport master (
    output wbu_receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i,
           csreg_en_i, ecall_i, ebreak_i, pc_i, pc_next_i, ifu_ready,
    input  wbu_send_ready, wbu_send_valid, pc_next_o
  );

  modport slave (
    input  wbu_receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i,
           csreg_en_i, ecall_i, ebreak_i, pc_i, pc_next_i, ifu_ready,
    output wbu_send_ready, wbu_send_valid, pc_next_o
  );
endinterface

// File: rtl/wbu_commit.sv
// Write-back/commit stage: owns the 32x32 GPR file and the four machine
// CSRs, applies the ecall trap update and hands the next PC to fetch.
// One working transaction plus a one-entry skid buffer.
// Optional feature macro: WBU_BYPASS_EN (forward in-flight COMMIT writes
// to the decode read ports).
module wbu_commit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = 32'h00001800,
  parameter logic [XLEN-1:0] ECALL_CAUSE = 32'd11
) (
  input  logic            clk,
  input  logic            rst,
  wbu_commit_if.slave     bus,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [1:0]      csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic [4:0]      rd_wbu_to_idu,
  output logic            wbu_state,
  output logic            halt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] csr_wd;
    logic [4:0]      rd;
    logic [1:0]      csr_rd;
    logic            reg_en;
    logic            csreg_en;
    logic            ecall;
    logic            ebreak;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
  } txn_t;

  // CSR indices
  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MTVEC   = 2'd1;
  localparam logic [1:0] CSR_MEPC    = 2'd2;
  localparam logic [1:0] CSR_MCAUSE  = 2'd3;

  state_t          r_state;
  state_t          w_next;
  txn_t            r_work;
  txn_t            r_buf;
  txn_t            w_in;
  logic            r_buffer;
  logic            r_halt;
  logic [XLEN-1:0] r_pc_next_o;
  logic [XLEN-1:0] r_gpr [32];
  logic [XLEN-1:0] r_csr [4];
  logic            w_accept;
  logic            w_commit;

  assign w_in = '{wd: bus.wd_i, csr_wd: bus.csr_wd_i, rd: bus.rd_i,
                  csr_rd: bus.csr_rd_i, reg_en: bus.reg_en_i,
                  csreg_en: bus.csreg_en_i, ecall: bus.ecall_i,
                  ebreak: bus.ebreak_i, pc: bus.pc_i, pc_next: bus.pc_next_i};

  // A halted core takes nothing more; a full buffer takes nothing more.
  assign bus.wbu_send_ready = !r_buffer && !r_halt;
  assign w_accept           = bus.wbu_receive_valid && bus.wbu_send_ready;
  assign w_commit           = (r_state == S_COMMIT);
  assign bus.pc_next_o      = r_pc_next_o;
  assign halt               = r_halt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: IDLE -> COMMIT -> SEND -> IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept || r_buffer) w_next = S_COMMIT;
      S_COMMIT: w_next = S_SEND;
      S_SEND:   if (bus.ifu_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs: send handshake, busy flag and hazard destination
  always_comb begin
    bus.wbu_send_valid = (r_state == S_SEND);
    wbu_state          = (r_state != S_IDLE);
    rd_wbu_to_idu      = (wbu_state && r_work.reg_en) ? r_work.rd : 5'd0;
`ifdef WBU_BYPASS_EN
    // The value is forwarded during COMMIT, so decode need not stall on it.
    if (w_commit) rd_wbu_to_idu = 5'd0;
`endif
  end

  // Capture: IDLE loads the working register (buffer first), busy states fill the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work   <= '0;
      r_buf    <= '0;
      r_buffer <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (r_buffer) begin
        r_work   <= r_buf;
        r_buffer <= 1'b0;
      end else if (w_accept) begin
        r_work <= w_in;
      end
    end else if (w_accept) begin
      r_buf    <= w_in;
      r_buffer <= 1'b1;
    end
  end

  // Architectural update on the COMMIT->SEND edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
      r_csr[CSR_MSTATUS] <= MSTATUS_RST;
      r_csr[CSR_MTVEC]   <= '0;
      r_csr[CSR_MEPC]    <= '0;
      r_csr[CSR_MCAUSE]  <= '0;
      r_pc_next_o        <= '0;
      r_halt             <= 1'b0;
    end else if (w_commit) begin
      if (r_work.reg_en && (r_work.rd != 5'd0)) r_gpr[r_work.rd] <= r_work.wd;
      if (r_work.csreg_en) r_csr[r_work.csr_rd] <= r_work.csr_wd;
      // Trap writes come last so they win over a same-commit CSR write.
      if (r_work.ecall) begin
        r_csr[CSR_MEPC]   <= r_work.pc;
        r_csr[CSR_MCAUSE] <= ECALL_CAUSE;
        r_pc_next_o       <= r_csr[CSR_MTVEC];
      end else begin
        r_pc_next_o <= r_work.pc_next;
      end
      if (r_work.ebreak) r_halt <= 1'b1;
    end
  end

  // Decode read ports: stored state, optionally with COMMIT-cycle forwarding
  always_comb begin
    rdata1    = (raddr1 == 5'd0) ? '0 : r_gpr[raddr1];
    rdata2    = (raddr2 == 5'd0) ? '0 : r_gpr[raddr2];
    csr_rdata = r_csr[csr_raddr];
`ifdef WBU_BYPASS_EN
    if (w_commit && r_work.reg_en && (r_work.rd != 5'd0)) begin
      if (raddr1 == r_work.rd) rdata1 = r_work.wd;
      if (raddr2 == r_work.rd) rdata2 = r_work.wd;
    end
    if (w_commit) begin
      if (r_work.ecall && (csr_raddr == CSR_MEPC))        csr_rdata = r_work.pc;
      else if (r_work.ecall && (csr_raddr == CSR_MCAUSE)) csr_rdata = ECALL_CAUSE;
      else if (r_work.csreg_en && (csr_raddr == r_work.csr_rd)) csr_rdata = r_work.csr_wd;
    end
`endif
  end

endmodule

// File: tb/tb_wbu_commit.sv
// Self-checking bench for wbu_commit. Inputs change 1 time unit after the
// rising edge; everything is observed on the falling edge.
module tb_wbu_commit;

  typedef struct packed {
    logic [31:0] wd;
    logic [31:0] csr_wd;
    logic [4:0]  rd;
    logic [1:0]  csr_rd;
    logic        reg_en;
    logic        csreg_en;
    logic        ecall;
    logic        ebreak;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wbu_commit_if bus ();
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, csr_rdata;
  logic [1:0]  csr_raddr;
  logic [4:0]  rd_wbu_to_idu;
  logic        wbu_state, halt;

  wbu_commit dut (
    .clk(clk), .rst(rst), .bus(bus),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .rd_wbu_to_idu(rd_wbu_to_idu), .wbu_state(wbu_state), .halt(halt)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- fetch-side ready ----------------
  logic ifu_rand  = 1'b0;
  logic ifu_fixed = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.ifu_ready = ifu_rand ? ($urandom_range(0, 3) != 0) : ifu_fixed;
  end

  // ---------------- reference model + scoreboard ----------------
  // Architectural effect of each accepted instruction, applied in accept order.
  logic [31:0] m_gpr [32];
  logic [31:0] m_csr [4];
  logic [31:0] exp_q [$];
  logic [31:0] epc;
  logic [31:0] prev_pc;
  logic        prev_wait;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_csr[0] = 32'h00001800;
      m_csr[1] = 32'd0;
      m_csr[2] = 32'd0;
      m_csr[3] = 32'd0;
      exp_q.delete();
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("send_held", {31'd0, bus.wbu_send_valid}, 32'd1);
        chk("pc_hold", bus.pc_next_o, prev_pc);
      end
      if (bus.wbu_send_valid && bus.ifu_ready) begin
        chk("send_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("pc_next", bus.pc_next_o, exp_q.pop_front());
      end
      prev_wait = bus.wbu_send_valid && !bus.ifu_ready;
      prev_pc   = bus.pc_next_o;
      if (bus.wbu_receive_valid && bus.wbu_send_ready) begin
        acc_cnt++;
        epc = bus.ecall_i ? m_csr[1] : bus.pc_next_i;
        if (bus.reg_en_i && bus.rd_i != 5'd0) m_gpr[bus.rd_i] = bus.wd_i;
        if (bus.csreg_en_i) m_csr[bus.csr_rd_i] = bus.csr_wd_i;
        if (bus.ecall_i) begin
          m_csr[2] = bus.pc_i;
          m_csr[3] = 32'd11;
        end
        exp_q.push_back(epc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic txn_t mk(input logic [4:0] rd, input logic [31:0] wd, input logic reg_en,
                              input logic [1:0] csr_rd, input logic [31:0] csr_wd,
                              input logic csreg_en, input logic ecall, input logic ebreak,
                              input logic [31:0] pc, input logic [31:0] pc_next);
    txn_t t;
    t = '{wd: wd, csr_wd: csr_wd, rd: rd, csr_rd: csr_rd, reg_en: reg_en,
          csreg_en: csreg_en, ecall: ecall, ebreak: ebreak, pc: pc, pc_next: pc_next};
    return t;
  endfunction

  task automatic put(input txn_t t);
    bus.wd_i = t.wd;           bus.csr_wd_i = t.csr_wd;
    bus.rd_i = t.rd;           bus.csr_rd_i = t.csr_rd;
    bus.reg_en_i = t.reg_en;   bus.csreg_en_i = t.csreg_en;
    bus.ecall_i = t.ecall;     bus.ebreak_i = t.ebreak;
    bus.pc_i = t.pc;           bus.pc_next_i = t.pc_next;
  endtask

  // Offer one transaction; returns 1 unit after the accepting edge.
  task automatic drive(input txn_t t);
    bit done = 0;
    int n = 0;
    put(t);
    bus.wbu_receive_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = bus.wbu_send_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.wbu_receive_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ifu_rand  = 1'b0;
    ifu_fixed = 1'b1;
    @(posedge clk); #2;
    while (n < 500 && !(exp_q.size() == 0 && !bus.wbu_send_valid && !wbu_state)) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Read back every GPR on both ports and every CSR.
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr1    = 5'(i);
      raddr2    = 5'(31 - i);
      csr_raddr = 2'(i);
      @(negedge clk);
      chk($sformatf("%s_r1_x%0d", tag, i), rdata1, m_gpr[i]);
      chk($sformatf("%s_r2_x%0d", tag, 31 - i), rdata2, m_gpr[31 - i]);
      if (i < 4) chk($sformatf("%s_csr%0d", tag, i), csr_rdata, m_csr[i]);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int a0;
  initial begin
    rst = 1'b1;
    bus.wbu_receive_valid = 1'b0;
    put('0);
    raddr1 = 5'd5; raddr2 = 5'd0; csr_raddr = 2'd0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mstatus", csr_rdata, 32'h00001800);
    chk("rst_ready", {31'd0, bus.wbu_send_ready}, 32'd1);
    chk("rst_send_valid", {31'd0, bus.wbu_send_valid}, 32'd0);
    chk("rst_pc_next", bus.pc_next_o, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_hazard", {27'd0, rd_wbu_to_idu}, 32'd0);
    @(posedge clk); #1;

    // Single write with latency checks, fetch holding off
    ifu_fixed = 1'b0;
    repeat (2) @(posedge clk); #1;
    drive(mk(5'd5, 32'hDEADBEEF, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h80000004));
    @(negedge clk);
    chk("wr_commit_valid", {31'd0, bus.wbu_send_valid}, 32'd0);
    chk("wr_commit_busy", {31'd0, wbu_state}, 32'd1);
`ifdef WBU_BYPASS_EN
    chk("wr_commit_hazard", {27'd0, rd_wbu_to_idu}, 32'd0);
    chk("wr_commit_rdata", rdata1, 32'hDEADBEEF);
`else
    chk("wr_commit_hazard", {27'd0, rd_wbu_to_idu}, 32'd5);
    chk("wr_commit_rdata", rdata1, 32'd0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_send_valid", {31'd0, bus.wbu_send_valid}, 32'd1);
    chk("wr_send_pc", bus.pc_next_o, 32'h80000004);
    chk("wr_send_rdata", rdata1, 32'hDEADBEEF);
    chk("wr_send_hazard", {27'd0, rd_wbu_to_idu}, 32'd5);
    drain();
    // Same transaction aimed at x0
    drive(mk(5'd0, 32'hCAFEF00D, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h80000004, 32'h80000008));
    drain();
    sweep("x0");

    // ecall: preset mtvec, then trap
    drive(mk(5'd1, 32'h11, 1'b1, 2'd1, 32'h80000100, 1'b1, 1'b0, 1'b0, 32'h80000020, 32'h80000024));
    drive(mk(5'd0, 32'd0, 1'b0, 2'd3, 32'h5555, 1'b1, 1'b1, 1'b0, 32'h80000040, 32'h80000044));
    drain();
    csr_raddr = 2'd2;
    @(negedge clk);
    chk("ecall_mepc", csr_rdata, 32'h80000040);
    @(posedge clk); #1;
    csr_raddr = 2'd3;
    @(negedge clk);
    chk("ecall_mcause", csr_rdata, 32'd11);
    chk("ecall_pc", bus.pc_next_o, 32'h80000100);
    @(posedge clk); #1;

    // Back-pressure: second item arrives during SEND and sits in the buffer
    ifu_fixed = 1'b0;
    repeat (2) @(posedge clk); #1;
    drive(mk(5'd10, 32'hA0A0A0A0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h80000200, 32'h80000204));
    @(posedge clk); #1;
    drive(mk(5'd11, 32'hB1B1B1B1, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h80000204, 32'h80000300));
    @(negedge clk);
    chk("bp_ready", {31'd0, bus.wbu_send_ready}, 32'd0);
    @(posedge clk); #1;
    repeat (5) @(posedge clk); #1;
    drain();
    sweep("bp");

    // Randomized traffic against the model
    ifu_rand = 1'b1;
    for (int k = 0; k < 80; k++) begin
      drive(mk(5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 4) != 0,
               2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0, 1'b0, {$urandom, 2'b00} & 32'hFFFFFFFC,
               $urandom & 32'hFFFFFFFC));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    sweep("rnd");

    // ebreak: halt from the commit edge, nothing accepted afterwards
    ifu_fixed = 1'b0;
    repeat (2) @(posedge clk); #1;
    drive(mk(5'd3, 32'h00001234, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h80000400, 32'h80000404));
    @(negedge clk);
    chk("ebrk_halt_commit", {31'd0, halt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ebrk_halt", {31'd0, halt}, 32'd1);
    chk("ebrk_ready", {31'd0, bus.wbu_send_ready}, 32'd0);
    @(posedge clk); #1;
    a0 = acc_cnt;
    put(mk(5'd4, 32'h4444, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h80000404, 32'h80000408));
    bus.wbu_receive_valid = 1'b1;
    repeat (8) @(posedge clk); #1;
    bus.wbu_receive_valid = 1'b0;
    chk("ebrk_no_accept", 32'(acc_cnt), 32'(a0));
    drain();
    chk("ebrk_halt_sticky", {31'd0, halt}, 32'd1);
    sweep("ebrk");
    do_reset();
    @(negedge clk);
    chk("ebrk_halt_cleared", {31'd0, halt}, 32'd0);
    @(posedge clk); #1;

    // Reset in COMMIT drops the write
    raddr1 = 5'd7;
    drive(mk(5'd7, 32'h77777777, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h80000500, 32'h80000504));
    do_reset();
    @(negedge clk);
    chk("midrst_x7", rdata1, 32'd0);
    chk("midrst_state", {31'd0, wbu_state}, 32'd0);
    chk("midrst_send_valid", {31'd0, bus.wbu_send_valid}, 32'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
